rfblackwidow_decode_seq: RTL and testbench
==========================================

RFBLACKWIDOW_DECODE_SEQ -- requirements
Module: rfblackwidow_decode_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, instruction queue entries (power of two, >=4).
REQ-002 SHALL have parameter INSN_W, default 40, instruction word width (package Instruction type).
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  synchronous, active-low reset.
REQ-005 SHALL have port flush_i  input  1  discard all queued words (branch/exception redirect).
REQ-006 SHALL have ports fetch_valid_i  input  1  and fetch_insn_i  input  INSN_W  one fetched word per cycle.
REQ-007 SHALL have port fetch_ready_o  output  1  queue can accept a word this cycle.
REQ-008 SHALL have ports dec_ir_o, dec_ir1_o, dec_ir2_o, dec_ir3_o  output  INSN_W each  decoder slot words (head + 3 postfix).
REQ-009 SHALL have port dec_len_o  output  3  words in issued group, 1..4.
REQ-010 SHALL have port dec_err_o  output  1  group is an orphan postfix (head opcode CON1/CON2/CON3).
REQ-011 SHALL have ports dec_valid_o  output  1  and dec_ready_i  input  1  decoder handshake.

Function
REQ-012 SHALL hold fetched words in a DEPTH-entry FIFO; push when fetch_valid_i && fetch_ready_o.
REQ-013 SHALL drive fetch_ready_o = (count < DEPTH) || (pop this cycle), combinationally.
REQ-014 SHALL compute n = consecutive words after head with opcode in {CON1,CON2,CON3}, saturating at 3.
REQ-015 SHALL consider a group complete when head+n words are queued and either n==3 or word head+n+1 is queued and is not a CON opcode.
REQ-016 SHALL treat a head word whose opcode is CONx as a length-1 group with dec_err_o=1, complete when present.
REQ-017 SHALL use states EMPTY (count==0), COLLECT (group incomplete), ISSUE (dec_valid_o=1); EMPTY->COLLECT on push, COLLECT->ISSUE on completion, ISSUE->COLLECT/EMPTY/ISSUE on handshake per remaining queue.
REQ-018 SHALL register dec_* outputs; dec_valid_o rises no earlier than the cycle after the completing word is pushed.
REQ-019 SHALL hold dec_ir*_o, dec_len_o, dec_err_o stable while dec_valid_o && !dec_ready_i.
REQ-020 SHALL pop dec_len_o words on dec_valid_o && dec_ready_i; slots beyond dec_len_o SHALL be driven zero.
REQ-021 SHALL support push and pop in the same cycle; count updates by +1-dec_len_o.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; group words may straddle the wrap.
REQ-023 SHALL, on flush_i, clear count, pointers and dec_valid_o next cycle, enter EMPTY, and ignore same-cycle push and pop (flush has priority).

Reset
REQ-024 SHALL, with rst_ni low at a clock edge, set count=0, pointers=0, state EMPTY, dec_valid_o=0, dec_len_o=1, dec_err_o=0, dec_ir*_o=0.
REQ-025 SHALL, with reset asserted mid-group, drop all queued words and any pending issue without completing handshake.

Configuration
REQ-026 SHALL, with RFBW_DECSEQ_PERF_EN defined, add outputs perf_issue_o (32b, handshakes) and perf_stall_o (32b, cycles in COLLECT with count>0), both reset to 0, wrapping at 2^32.
REQ-027 SHALL, without RFBW_DECSEQ_PERF_EN, omit those ports and counters entirely.

Structure
REQ-028 SHALL take Instruction, CON1/CON2/CON3 opcodes and opcode field extraction from rfBlackWidowPkg; seq state enum SHALL be added there.
REQ-029 SHALL instantiate one sub-module rfblackwidow_con_scan (combinational n/err computation from 5 lookahead words + valid bits).

Verification
REQ-030 Push ADDI, ADDI -> dec_valid_o with len=1 for first after second arrives; dec_ready_i=1 pops one per handshake.
REQ-031 Push LDO, CON1, CON2, CON3 -> single group len=4, ir1..ir3 = the CON words, no lookahead needed.
REQ-032 Push ADDI, CON1, then stall fetch 5 cycles, then ORI -> dec_valid_o stays 0 five cycles, then len=2 group.
REQ-033 Push CON2 as head -> len=1, dec_err_o=1.
REQ-034 Fill 8 words with dec_ready_i=0 -> fetch_ready_o=0; outputs stable; release -> pointers wrap, order preserved.
REQ-035 Assert flush_i with queue 5 and dec_valid_o=1 while fetch_valid_i=1 -> next cycle count=0, dec_valid_o=0, pushed word discarded.

Source files
------------

// File: rtl/rfBlackWidowPkg.sv
// rfBlackWidowPkg: shared instruction type, opcode encodings and decode-sequencer
// state type for the RF BlackWidow front end.
package rfBlackWidowPkg;

   localparam int unsigned INSN_W_DEF = 40;
   localparam int unsigned OPC_W      = 8;

   // Opcode occupies the top OPC_W bits of an instruction word
   typedef logic [INSN_W_DEF-1:0] Instruction;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP  = 8'h00,
      OP_ADDI = 8'h13,
      OP_ORI  = 8'h14,
      OP_LDO  = 8'h20,
      OP_CON1 = 8'hC1,
      OP_CON2 = 8'hC2,
      OP_CON3 = 8'hC3
   } opcode_e;

   typedef enum logic [1:0] {
      SEQ_EMPTY,
      SEQ_COLLECT,
      SEQ_ISSUE
   } seq_state_e;

   function automatic logic [OPC_W-1:0] get_opcode(input Instruction insn);
      return insn[INSN_W_DEF-1 -: OPC_W];
   endfunction

   function automatic logic is_con(input logic [OPC_W-1:0] op);
      return (op == OP_CON1) || (op == OP_CON2) || (op == OP_CON3);
   endfunction

endpackage

// File: rtl/rfblackwidow_con_scan.sv
// rfblackwidow_con_scan: combinational postfix scan over a five-word window
// starting at the group head. Reports the CON run length behind the head,
// whether the head itself is an orphan postfix, and whether the group is
// fully known (run saturated or terminated by a queued non-CON word).
module rfblackwidow_con_scan
   import rfBlackWidowPkg::*;
(
   input  logic [4:0][OPC_W-1:0] ops_i,
   input  logic [4:0]            vld_i,
   output logic [1:0]            n_o,
   output logic                  err_o,
   output logic                  complete_o
);

   logic [1:0] n;
   logic       run;
   logic [2:0] nxt;

   // Count the CON run behind the head, then inspect the word just past it
   always_comb begin
      n   = 2'd0;
      run = 1'b1;
      for (int unsigned i = 1; i < 4; i++) begin
         if (run && vld_i[i] && is_con(ops_i[i])) begin
            n = n + 2'd1;
         end else begin
            run = 1'b0;
         end
      end
      err_o = vld_i[0] && is_con(ops_i[0]);
      if (err_o) begin
         n = 2'd0;
      end
      nxt        = 3'(n) + 3'd1;
      n_o        = n;
      complete_o = vld_i[0] &&
                   (err_o || (n == 2'd3) || (vld_i[nxt] && !is_con(ops_i[nxt])));
   end

endmodule

// File: rtl/rfblackwidow_decode_seq.sv
// rfblackwidow_decode_seq: fetch-side instruction queue that assembles a head
// word plus up to three CON postfix words into one decoder group and issues it
// over a valid/ready handshake.
// Optional build macro: RFBW_DECSEQ_PERF_EN adds perf_issue_o / perf_stall_o.
module rfblackwidow_decode_seq
   import rfBlackWidowPkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned INSN_W = INSN_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              fetch_valid_i,
   input  logic [INSN_W-1:0] fetch_insn_i,
   output logic              fetch_ready_o,
   output logic [INSN_W-1:0] dec_ir_o,
   output logic [INSN_W-1:0] dec_ir1_o,
   output logic [INSN_W-1:0] dec_ir2_o,
   output logic [INSN_W-1:0] dec_ir3_o,
   output logic [2:0]        dec_len_o,
   output logic              dec_err_o,
   output logic              dec_valid_o,
   input  logic              dec_ready_i
`ifdef RFBW_DECSEQ_PERF_EN
   ,
   output logic [31:0]       perf_issue_o,
   output logic [31:0]       perf_stall_o
`endif
);

   localparam int unsigned      PTR_W   = $clog2(DEPTH);
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [INSN_W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q, base_ptr;
   logic [CNT_W-1:0]      count_q, count_d, pop_len, avail;
   seq_state_e            state_q;
   logic                  dec_valid_q, dec_err_q;
   logic [2:0]            dec_len_q;
   logic [INSN_W-1:0]     dec_ir_q [4];

   logic                  hs, push, load;
   logic [4:0][OPC_W-1:0] scan_op;
   logic [4:0]            scan_vld;
   logic [1:0]            scan_n;
   logic                  scan_err, scan_complete;
   logic [2:0]            grp_len;
   logic [INSN_W-1:0]     grp_ir [4];

   assign hs            = dec_valid_q && dec_ready_i;
   assign fetch_ready_o = (count_q < DEPTH_C) || hs;
   assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
   assign pop_len       = hs ? CNT_W'(dec_len_q) : '0;
   // Scanning starts past the group leaving this cycle so back-to-back issue works;
   // a word pushed in the same cycle is deliberately not visible to the scan.
   assign base_ptr      = rd_ptr_q + pop_len[PTR_W-1:0];
   assign avail         = count_q - pop_len;
   assign count_d       = avail + CNT_W'(push);
   assign load          = scan_complete &&
                          ((state_q == SEQ_COLLECT) || ((state_q == SEQ_ISSUE) && hs));

   // Five-word lookahead window beginning at the next group head
   always_comb begin
      scan_op  = '0;
      scan_vld = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         scan_op[i]  = get_opcode(Instruction'(mem_q[base_ptr + PTR_W'(i)]));
         scan_vld[i] = CNT_W'(i) < avail;
      end
   end

   rfblackwidow_con_scan u_con_scan (
      .ops_i      (scan_op),
      .vld_i      (scan_vld),
      .n_o        (scan_n),
      .err_o      (scan_err),
      .complete_o (scan_complete)
   );

   // Candidate group words; slots beyond the group length read as zero
   always_comb begin
      grp_len = scan_err ? 3'd1 : (3'(scan_n) + 3'd1);
      grp_ir  = '{default: '0};
      for (int unsigned k = 0; k < 4; k++) begin
         if (3'(k) < grp_len) begin
            grp_ir[k] = mem_q[base_ptr + PTR_W'(k)];
         end
      end
   end

   // Queue storage; reset and flush only move pointers, stale data is harmless
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= fetch_insn_i;
      end
   end

   // Pointer/count bookkeeping and issue FSM with registered decoder outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= SEQ_EMPTY;
         dec_valid_q <= 1'b0;
         dec_len_q   <= 3'd1;
         dec_err_q   <= 1'b0;
         dec_ir_q    <= '{default: '0};
      end else if (flush_i) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= SEQ_EMPTY;
         dec_valid_q <= 1'b0;
      end else begin
         rd_ptr_q <= base_ptr;
         wr_ptr_q <= wr_ptr_q + PTR_W'(push);
         count_q  <= count_d;
         if (load) begin
            state_q     <= SEQ_ISSUE;
            dec_valid_q <= 1'b1;
            dec_ir_q    <= grp_ir;
            dec_len_q   <= grp_len;
            dec_err_q   <= scan_err;
         end else begin
            unique case (state_q)
               SEQ_EMPTY: begin
                  if (push) begin
                     state_q <= SEQ_COLLECT;
                  end
               end
               SEQ_COLLECT: begin
                  state_q <= SEQ_COLLECT;
               end
               SEQ_ISSUE: begin
                  if (hs) begin
                     dec_valid_q <= 1'b0;
                     state_q     <= (count_d == '0) ? SEQ_EMPTY : SEQ_COLLECT;
                  end
               end
               default: begin
                  state_q <= SEQ_EMPTY;
               end
            endcase
         end
      end
   end

   assign dec_ir_o    = dec_ir_q[0];
   assign dec_ir1_o   = dec_ir_q[1];
   assign dec_ir2_o   = dec_ir_q[2];
   assign dec_ir3_o   = dec_ir_q[3];
   assign dec_len_o   = dec_len_q;
   assign dec_err_o   = dec_err_q;
   assign dec_valid_o = dec_valid_q;

`ifdef RFBW_DECSEQ_PERF_EN
   logic [31:0] perf_issue_q, perf_stall_q;

   // Issued-group count and cycles spent waiting on an incomplete group
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_issue_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (hs && !flush_i) begin
            perf_issue_q <= perf_issue_q + 32'd1;
         end
         if ((state_q == SEQ_COLLECT) && (count_q != '0)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_issue_o = perf_issue_q;
   assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_rfblackwidow_decode_seq.sv
// Self-checking bench for rfblackwidow_decode_seq: directed scenarios followed
// by randomized fetch/decode/flush traffic, all checked against a queue-based
// reference model of the grouping rules.
module tb_rfblackwidow_decode_seq;
   import rfBlackWidowPkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned W     = 40;

   logic         clk = 1'b0;
   logic         rst_n, flush, fv, rdy;
   logic [W-1:0] insn;
   logic         fready, dvalid, derr;
   logic [W-1:0] ir0, ir1, ir2, ir3;
   logic [2:0]   dlen;
`ifdef RFBW_DECSEQ_PERF_EN
   logic [31:0]  perf_issue, perf_stall;
`endif

   always #5 clk = ~clk;

   rfblackwidow_decode_seq #(.DEPTH(DEPTH), .INSN_W(W)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .flush_i       (flush),
      .fetch_valid_i (fv),
      .fetch_insn_i  (insn),
      .fetch_ready_o (fready),
      .dec_ir_o      (ir0),
      .dec_ir1_o     (ir1),
      .dec_ir2_o     (ir2),
      .dec_ir3_o     (ir3),
      .dec_len_o     (dlen),
      .dec_err_o     (derr),
      .dec_valid_o   (dvalid),
      .dec_ready_i   (rdy)
`ifdef RFBW_DECSEQ_PERF_EN
      ,
      .perf_issue_o  (perf_issue),
      .perf_stall_o  (perf_stall)
`endif
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: words currently held in the queue and the edge each arrived on
   logic [W-1:0] mq[$];
   int unsigned  ms[$];
   int unsigned  cyc = 0;
   int unsigned  late = 0;
   bit           prev_flush = 0, prev_hold = 0, prev_valid = 0, prev_hs = 0;

   function automatic bit is_con_w(input logic [W-1:0] w);
      logic [7:0] op;
      op = w[W-1 -: 8];
      return (op == 8'hC1) || (op == 8'hC2) || (op == 8'hC3);
   endfunction

   function automatic logic [W-1:0] mk(input logic [7:0] op, input logic [31:0] pl);
      return {op, pl};
   endfunction

   function automatic logic [W-1:0] rnd_word();
      logic [7:0] op;
      case ($urandom_range(0, 9))
         0, 1, 2: op = OP_ADDI;
         3:       op = OP_ORI;
         4:       op = OP_LDO;
         5, 6:    op = OP_CON1;
         7:       op = OP_CON2;
         8:       op = OP_CON3;
         default: op = 8'h55;
      endcase
      return mk(op, $urandom);
   endfunction

   // Group at the model's queue head: head + up to 3 CON words, orphan CON is len 1
   task automatic model_group(output bit comp, output int unsigned len,
                              output bit err, output int unsigned last);
      int unsigned n;
      comp = 0; len = 1; err = 0; last = 0; n = 0;
      if (mq.size() == 0) return;
      if (is_con_w(mq[0])) begin
         comp = 1; err = 1;
         return;
      end
      while (n < 3 && n + 1 < mq.size() && is_con_w(mq[n+1])) n++;
      len = n + 1;
      if (n == 3) begin
         comp = 1; last = 3;
      end else if (mq.size() > n + 1) begin
         comp = 1; last = n + 1;
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, check, then model the rising edge
   task automatic step(input bit f_v, input logic [W-1:0] f_w, input bit r, input bit fl);
      bit          comp, err, hs, pushed;
      int unsigned len, last;
      fv = f_v; insn = f_w; rdy = r; flush = fl;
      #1;
      model_group(comp, len, err, last);
      if (prev_flush) check("valid_after_flush", dvalid, 0);
      else if (prev_hold) check("valid_held", dvalid, 1);
      if (dvalid) begin
         check("group_complete", comp, 1);
         if (comp) begin
            check("len", dlen, len);
            check("err", derr, err);
            check("ir0", ir0, mq[0]);
            check("ir1", ir1, (len > 1) ? mq[1] : '0);
            check("ir2", ir2, (len > 2) ? mq[2] : '0);
            check("ir3", ir3, (len > 3) ? mq[3] : '0);
            if (!prev_valid || prev_hs) check("issue_not_early", ms[last] < cyc, 1);
         end
         late = 0;
      end else if (comp) begin
         late++;
         check("issue_latency", late <= 1, 1);
      end else begin
         late = 0;
      end
      check("fetch_ready", fready, (mq.size() < DEPTH) || (dvalid && r));
      hs     = dvalid && r && !fl;
      pushed = f_v && fready && !fl;
      if (fl) begin
         mq.delete(); ms.delete();
      end else begin
         if (hs) begin
            for (int unsigned k = 0; k < len; k++) begin
               if (mq.size() > 0) begin
                  void'(mq.pop_front()); void'(ms.pop_front());
               end
            end
         end
         if (pushed) begin
            mq.push_back(f_w); ms.push_back(cyc + 1);
         end
      end
      prev_flush = fl;
      prev_hold  = dvalid && !r && !fl;
      prev_valid = dvalid;
      prev_hs    = hs;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      int unsigned k = 0;
      while (!dvalid && k < 6) begin
         step(0, '0, 0, 0);
         k++;
      end
      check(tag, dvalid, 1);
   endtask

   task automatic do_reset();
      rst_n = 0; fv = 0; rdy = 0; flush = 0; insn = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", dvalid, 0);
      check("rst_len", dlen, 1);
      check("rst_err", derr, 0);
      check("rst_ir", {24'd0, ir0 | ir1 | ir2 | ir3}, 0);
      check("rst_ready", fready, 1);
      rst_n = 1;
      mq.delete(); ms.delete();
      late = 0; prev_flush = 0; prev_hold = 0; prev_valid = 0; prev_hs = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] a, b, snap;
      @(negedge clk);
      do_reset();

      // Two plain words: first issues alone once the second provides lookahead
      a = mk(OP_ADDI, 32'h1111); b = mk(OP_ADDI, 32'h2222);
      step(1, a, 0, 0);
      step(1, b, 0, 0);
      wait_valid("t030_valid");
      check("t030_len", dlen, 1);
      check("t030_ir0", ir0, a);
      step(0, '0, 1, 0);
      check("t030_single_no_lookahead", dvalid, 0);
      do_reset();

      // Full four-word group needs no lookahead
      step(1, mk(OP_LDO,  32'hA0), 0, 0);
      step(1, mk(OP_CON1, 32'hA1), 0, 0);
      step(1, mk(OP_CON2, 32'hA2), 0, 0);
      step(1, mk(OP_CON3, 32'hA3), 0, 0);
      wait_valid("t031_valid");
      check("t031_len", dlen, 4);
      check("t031_ir3", ir3, mk(OP_CON3, 32'hA3));
      step(0, '0, 1, 0);
      check("t031_drained", dvalid, 0);
      do_reset();

      // Incomplete group waits through a fetch stall
      step(1, mk(OP_ADDI, 32'hB0), 0, 0);
      step(1, mk(OP_CON1, 32'hB1), 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, '0, 0, 0);
         check("t032_stall_no_valid", dvalid, 0);
      end
      step(1, mk(OP_ORI, 32'hB2), 0, 0);
      wait_valid("t032_valid");
      check("t032_len", dlen, 2);
      step(0, '0, 1, 0);
      do_reset();

      // Orphan postfix at the head; reset lands while it is still pending
      step(1, mk(OP_CON2, 32'hC0), 0, 0);
      wait_valid("t033_valid");
      check("t033_err", derr, 1);
      check("t033_len", dlen, 1);
      step(0, '0, 0, 0);
      do_reset();

      // Fill the queue with the decoder stalled, then release and wrap pointers
      for (int i = 0; i < 8; i++) step(1, mk(OP_ADDI, 32'(i)), 0, 0);
      step(1, mk(OP_ADDI, 32'hDEAD), 0, 0);
      check("t034_full_ready", fready, 0);
      snap = ir0;
      step(0, '0, 0, 0);
      step(0, '0, 0, 0);
      check("t034_stall_stable", ir0, snap);
      for (int i = 0; i < 10; i++) step(1, rnd_word(), 1, 0);
      for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
      do_reset();

      // Flush with a valid group and a same-cycle fetch
      for (int i = 0; i < 5; i++) step(1, mk(OP_ADDI, 32'hE0 + 32'(i)), 0, 0);
      wait_valid("t035_valid");
      step(1, mk(OP_ORI, 32'hEEEE), 0, 1);
      check("t035_flush_valid", dvalid, 0);
      step(0, '0, 0, 0);
      check("t035_flush_empty_ready", fready, 1);
      check("t035_flush_no_valid", dvalid, 0);
      step(1, mk(OP_LDO, 32'hF0), 0, 0);
      step(1, mk(OP_ADDI, 32'hF1), 0, 0);
      wait_valid("t035_after_flush_valid");
      check("t035_head_after_flush", ir0, mk(OP_LDO, 32'hF0));
      do_reset();

      // Randomized traffic with occasional flush and one reset mid-stream
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         step($urandom_range(0, 9) < 7, rnd_word(), $urandom_range(0, 9) < 6,
              $urandom_range(0, 99) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
